// File: rtl/video_pkg.sv
// Shared video-path types: scanline darkening modes and the
// default colour-channel width.
package video_pkg;

  localparam int CW_DEFAULT = 8;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_25  = 2'd1,
    SL_50  = 2'd2,
    SL_75  = 2'd3
  } scanline_mode_t;

endpackage

// File: rtl/scanline_dim.sv
// Combinational darkening of one colour channel.
// Ports: c (channel in), mode (darkening mode), y (channel out).
module scanline_dim
  import video_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic [CW-1:0]  c,
  input  scanline_mode_t mode,
  output logic [CW-1:0]  y
);

  always_comb begin
    y = c;
    case (mode)
      SL_25:   y = c - (c >> 2);
      SL_50:   y = c >> 1;
      SL_75:   y = c >> 2;
      default: y = c;
    endcase
  end

endmodule

// File: rtl/video_scanlines.sv
// CRT scanline emulation: darkens every other active line, 2 ce_pix latency.
// Ports: clk_video, rst_n, ce_pix, scanlines, din/de_in/hs_in/vs_in -> dout/de_out/hs_out/vs_out.
// Build option SCANLINES_ALT_PHASE_EN: swap dark/bright line phase every frame.
module video_scanlines
  import video_pkg::*;
#(
  parameter int CW = CW_DEFAULT
) (
  input  logic            clk_video,
  input  logic            rst_n,
  input  logic            ce_pix,
  input  logic [1:0]      scanlines,
  input  logic [3*CW-1:0] din,
  input  logic            de_in,
  input  logic            hs_in,
  input  logic            vs_in,
  output logic [3*CW-1:0] dout,
  output logic            de_out,
  output logic            hs_out,
  output logic            vs_out
);

  localparam int PW = 3 * CW;

  logic           hs_d;
  logic           vs_d;
  logic           hs_rise;
  logic           vs_rise;
  logic           seen_de;
  logic           parity;
  logic           par_rst;
  scanline_mode_t mode_q;

  logic [PW-1:0]  pix_s1;
  logic [PW-1:0]  pix_dim;
  logic           de_s1;
  logic           hs_s1;
  logic           vs_s1;
  logic           dim_s1;
  scanline_mode_t mode_s1;

  assign hs_rise = ce_pix & hs_in & ~hs_d;
  assign vs_rise = ce_pix & vs_in & ~vs_d;

`ifdef SCANLINES_ALT_PHASE_EN
  logic frame_q;

  always_ff @(posedge clk_video or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= 1'b0;
    end else if (vs_rise) begin
      frame_q <= ~frame_q;
    end
  end

  // Parity restarts at the frame bit value it is about to take.
  assign par_rst = ~frame_q;
`else
  assign par_rst = 1'b0;
`endif

  // Line phase: blank lines (no DE seen) do not advance parity,
  // and a vsync edge overrides a coincident hsync edge.
  always_ff @(posedge clk_video or negedge rst_n) begin
    if (!rst_n) begin
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      seen_de <= 1'b0;
      parity  <= 1'b0;
      mode_q  <= SL_OFF;
    end else if (ce_pix) begin
      hs_d    <= hs_in;
      vs_d    <= vs_in;
      seen_de <= (hs_rise | vs_rise) ? 1'b0 : (seen_de | de_in);
      if (vs_rise) begin
        parity <= par_rst;
        mode_q <= scanline_mode_t'(scanlines);
      end else if (hs_rise && seen_de) begin
        parity <= ~parity;
      end
    end
  end

  always_ff @(posedge clk_video or negedge rst_n) begin
    if (!rst_n) begin
      pix_s1  <= '0;
      de_s1   <= 1'b0;
      hs_s1   <= 1'b0;
      vs_s1   <= 1'b0;
      dim_s1  <= 1'b0;
      mode_s1 <= SL_OFF;
    end else if (ce_pix) begin
      pix_s1  <= din;
      de_s1   <= de_in;
      hs_s1   <= hs_in;
      vs_s1   <= vs_in;
      dim_s1  <= de_in & parity & (mode_q != SL_OFF);
      mode_s1 <= mode_q;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_dim
    scanline_dim #(
      .CW(CW)
    ) u_dim (
      .c   (pix_s1[i*CW +: CW]),
      .mode(mode_s1),
      .y   (pix_dim[i*CW +: CW])
    );
  end

  always_ff @(posedge clk_video or negedge rst_n) begin
    if (!rst_n) begin
      dout   <= '0;
      de_out <= 1'b0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
    end else if (ce_pix) begin
      dout   <= dim_s1 ? pix_dim : pix_s1;
      de_out <= de_s1;
      hs_out <= hs_s1;
      vs_out <= vs_s1;
    end
  end

endmodule

// File: tb/tb_video_scanlines.sv
// Self-checking bench for video_scanlines: table vectors,
// corner sequences and randomized frames against a line-count model.
module tb_video_scanlines;

`ifdef SCANLINES_ALT_PHASE_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  logic        clk_video = 1'b0;
  logic        rst_n     = 1'b0;
  logic        ce_pix    = 1'b0;
  logic [1:0]  scanlines = 2'd0;
  logic [23:0] din       = '0;
  logic        de_in     = 1'b0;
  logic        hs_in     = 1'b0;
  logic        vs_in     = 1'b0;
  logic [23:0] dout;
  logic        de_out;
  logic        hs_out;
  logic        vs_out;

  always #5 clk_video = ~clk_video;

  video_scanlines #(.CW(8)) dut (
    .clk_video(clk_video),
    .rst_n    (rst_n),
    .ce_pix   (ce_pix),
    .scanlines(scanlines),
    .din      (din),
    .de_in    (de_in),
    .hs_in    (hs_in),
    .vs_in    (vs_in),
    .dout     (dout),
    .de_out   (de_out),
    .hs_out   (hs_out),
    .vs_out   (vs_out)
  );

  typedef struct packed {
    logic [23:0] pix;
    logic        de;
    logic        hs;
    logic        vs;
  } out_t;

  typedef struct {
    logic [1:0]  mode;
    logic [23:0] pix;
    logic [23:0] bright;
    logic [23:0] dark;
  } vec_t;

  out_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   line_cnt;
  int   frame_cnt;
  int   mode_m;
  bit   seen_m;
  bit   hs_dm;
  bit   vs_dm;
  int   ce_div = 1;
  int   nfr = 0;

  function automatic logic [7:0] dim8(logic [7:0] c, int m);
    case (m)
      1:       return c - c / 4;
      2:       return c / 2;
      3:       return c / 4;
      default: return c;
    endcase
  endfunction

  function automatic logic [23:0] dim_px(logic [23:0] p, int m);
    return {dim8(p[23:16], m), dim8(p[15:8], m), dim8(p[7:0], m)};
  endfunction

  // Line l of frame f is dark when this is 1.
  function automatic bit par_of(int l, int f);
    return bit'((l + (ALT ? f : 0)) % 2);
  endfunction

  task automatic model_reset();
    q.delete();
    q.push_back('0);
    q.push_back('0);
    line_cnt  = 0;
    frame_cnt = 0;
    mode_m    = 0;
    seen_m    = 0;
    hs_dm     = 0;
    vs_dm     = 0;
  endtask

  task automatic model_ce();
    bit   hr;
    bit   vr;
    out_t o;
    hr = hs_in && !hs_dm;
    vr = vs_in && !vs_dm;
    if (de_in && par_of(line_cnt, frame_cnt) && mode_m != 0)
      o.pix = dim_px(din, mode_m);
    else
      o.pix = din;
    o.de = de_in;
    o.hs = hs_in;
    o.vs = vs_in;
    q.push_back(o);
    void'(q.pop_front());
    if (vr) begin
      frame_cnt++;
      line_cnt = 0;
      mode_m   = int'(scanlines);
      seen_m   = 0;
    end else if (hr) begin
      if (seen_m) line_cnt++;
      seen_m = 0;
    end else if (de_in) begin
      seen_m = 1;
    end
    hs_dm = hs_in;
    vs_dm = vs_in;
  endtask

  task automatic check(string name, logic [26:0] act, logic [26:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(bit ce);
    ce_pix = ce;
    @(posedge clk_video);
    #1;
    if (ce) model_ce();
    check("pipe", {dout, de_out, hs_out, vs_out}, q[0]);
  endtask

  task automatic step();
    for (int i = 1; i < ce_div; i++) tick(1'b0);
    tick(1'b1);
  endtask

  task automatic put(logic [23:0] p, bit de, bit hs, bit vs);
    din   = p;
    de_in = de;
    hs_in = hs;
    vs_in = vs;
    step();
  endtask

  task automatic do_line(int npix, bit active, logic [23:0] pix,
                         bit rnd, bit chk, logic [23:0] exp);
    for (int j = 0; j < npix; j++) begin
      put(rnd ? 24'($urandom) : pix, active, 1'b0, 1'b0);
      if (chk && active && j == 4)
        check("line", {dout, de_out, 2'b00}, {exp, 1'b1, 2'b00});
    end
    put('0, 0, 0, 0);
    put('0, 0, 0, 0);
    put('0, 0, 1, 0);
    put('0, 0, 1, 0);
    put('0, 0, 0, 0);
  endtask

  task automatic do_vsync(logic [1:0] sl);
    scanlines = sl;
    for (int i = 0; i < 3; i++) put('0, 0, 0, 1);
    put('0, 0, 0, 0);
    put('0, 0, 0, 0);
    nfr++;
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{2'd0, 24'hFF8040, 24'hFF8040, 24'hFF8040};
    tbl[1] = '{2'd2, 24'hFF8040, 24'hFF8040, 24'h7F4020};
    tbl[2] = '{2'd1, 24'hFF0004, 24'hFF0004, 24'hC00003};
    tbl[3] = '{2'd3, 24'hFF0004, 24'hFF0004, 24'h3F0001};

    model_reset();
    repeat (3) @(posedge clk_video);
    #1;
    check("reset", {dout, de_out, hs_out, vs_out}, 27'd0);
    rst_n = 1'b1;

    // Table: two blank lines then four active lines per mode.
    for (int t = 0; t < 4; t++) begin
      do_vsync(tbl[t].mode);
      do_line(6, 0, '0, 0, 0, '0);
      do_line(6, 0, '0, 0, 0, '0);
      for (int l = 0; l < 4; l++)
        do_line(6, 1, tbl[t].pix, 0, 1,
                par_of(l, nfr) ? tbl[t].dark : tbl[t].bright);
    end

    // Mode change mid-frame waits for the next vsync edge.
    do_vsync(2'd2);
    for (int l = 0; l < 8; l++) begin
      if (l == 5) scanlines = 2'd3;
      do_line(6, 1, 24'hFF8040, 0, 1,
              par_of(l, nfr) ? 24'h7F4020 : 24'hFF8040);
    end
    do_vsync(2'd3);
    for (int l = 0; l < 2; l++)
      do_line(6, 1, 24'hFF8040, 0, 1,
              par_of(l, nfr) ? 24'h3F2010 : 24'hFF8040);

    // ce_pix every third cycle; hs and vs rise together.
    ce_div = 3;
    do_vsync(2'd2);
    do_line(6, 1, 24'hFF8040, 0, 1, par_of(0, nfr) ? 24'h7F4020 : 24'hFF8040);
    put('0, 0, 1, 1);
    put('0, 0, 1, 1);
    put('0, 0, 0, 0);
    put('0, 0, 0, 0);
    nfr++;
    for (int l = 0; l < 2; l++)
      do_line(6, 1, 24'hFF8040, 0, 1,
              par_of(l, nfr) ? 24'h7F4020 : 24'hFF8040);
    ce_div = 1;

    // Asynchronous reset in the middle of an active line.
    do_vsync(2'd2);
    do_line(6, 1, 24'hFF8040, 0, 0, '0);
    put(24'h123456, 1, 0, 0);
    put(24'h123456, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid", {dout, de_out, hs_out, vs_out}, 27'd0);
    ce_pix = 1'b0;
    de_in  = 1'b0;
    din    = '0;
    model_reset();
    nfr = 0;
    @(posedge clk_video);
    #1;
    rst_n = 1'b1;
    do_vsync(2'd2);
    for (int l = 0; l < 3; l++)
      do_line(6, 1, 24'hFF8040, 0, 1,
              par_of(l, nfr) ? 24'h7F4020 : 24'hFF8040);

    // Randomized frames, checked cycle by cycle against the model.
    for (int f = 0; f < 8; f++) begin
      ce_div = int'($urandom_range(1, 3));
      do_vsync(2'($urandom));
      for (int l = 0; l < int'($urandom_range(3, 6)); l++) begin
        if ($urandom_range(0, 4) == 0) scanlines = 2'($urandom);
        do_line(int'($urandom_range(2, 8)), ($urandom_range(0, 3) != 0),
                '0, 1, 0, '0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
